// File: rtl/sstu_pkg.sv
// Shared codes and sizes for the SSTU controller/datapath interface.
package sstu_pkg;

  localparam int DW   = 8;
  localparam int NREG = 16;
  localparam int AW   = 4;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_XOR = 2'd1,
    OP_ADD = 2'd2,
    OP_ROL = 2'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    SRC_A     = 3'd0,
    SRC_B     = 3'd1,
    SRC_CONST = 3'd2,
    SRC_ALU   = 3'd3,
    SRC_FB    = 3'd4
  } src_sel_e;

  localparam logic [AW-1:0] ADDR_OUT  = 4'd0;
  localparam logic [AW-1:0] ADDR_INA  = 4'd1;
  localparam logic [AW-1:0] ADDR_INB  = 4'd2;
  localparam logic [AW-1:0] ADDR_GEN0 = 4'd3;

endpackage

// File: rtl/sstu_alu.sv
// Combinational ALU: AND / XOR / ADD with carry / rotate-left of op1.
module sstu_alu
  import sstu_pkg::*;
#(
  parameter int W = sstu_pkg::DW
) (
  input  logic [W-1:0] op1_i,
  input  logic [W-1:0] op2_i,
  input  logic [1:0]   insel_i,
  output logic [W-1:0] result_o,
  output logic         z_o,
  output logic         co_o
);

  logic [W:0] sum;

  assign sum = {1'b0, op1_i} + {1'b0, op2_i};

  always_comb begin
    result_o = '0;
    co_o     = 1'b0;
    case (insel_i)
      OP_AND: result_o = op1_i & op2_i;
      OP_XOR: result_o = op1_i ^ op2_i;
      OP_ADD: begin
        result_o = sum[W-1:0];
        co_o     = sum[W];
      end
      OP_ROL: result_o = {op1_i[W-2:0], op1_i[W-1]};
      default: result_o = '0;
    endcase
  end

  // Rotate keeps zero-ness, so z doubles as a zero test of op1 under OP_ROL.
  assign z_o = (result_o == '0);

endmodule

// File: rtl/sstu_datapath.sv
// SSTU datapath: register file (out/inA/inB/general), write-data mux,
// feedback read port and ALU, driven by the exponentiation control unit.
module sstu_datapath
  import sstu_pkg::*;
#(
  parameter int DW   = sstu_pkg::DW,
  parameter int NREG = sstu_pkg::NREG
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  input  logic [DW-1:0] cu_const,
  input  logic [1:0]    insel,
  input  logic [2:0]    in_mux_add,
  input  logic [3:0]    out_mux_add,
  input  logic [3:0]    reg_add,
  input  logic          we,
  output logic [DW-1:0] data_out,
  output logic          out_valid,
  output logic          z,
  output logic          co
);

  logic [DW-1:0] regs_q [NREG];
  logic          out_valid_q;
  logic          out_valid_d;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] fb_data;
  logic [DW-1:0] alu_result;

  // Feedback reads the pre-edge contents, so a same-cycle write to the
  // same address returns the old value.
  always_comb begin
    fb_data = '0;
    if (int'(out_mux_add) < NREG) fb_data = regs_q[out_mux_add];
  end

  always_comb begin
    wr_data = '0;
    case (in_mux_add)
      SRC_A:     wr_data = a_in;
      SRC_B:     wr_data = b_in;
      SRC_CONST: wr_data = cu_const;
      SRC_ALU:   wr_data = alu_result;
      SRC_FB:    wr_data = fb_data;
      default:   wr_data = '0;
    endcase
  end

  assign out_valid_d = we && (reg_add == ADDR_OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (we && (int'(reg_add) < NREG)) regs_q[reg_add] <= wr_data;
      out_valid_q <= out_valid_d;
    end
  end

  sstu_alu #(.W(DW)) u_alu (
    .op1_i    (regs_q[ADDR_INA]),
    .op2_i    (regs_q[ADDR_INB]),
    .insel_i  (insel),
    .result_o (alu_result),
    .z_o      (z),
    .co_o     (co)
  );

  assign data_out  = regs_q[ADDR_OUT];
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sstu_datapath.sv
// Directed bench for sstu_datapath with hand-computed expectations.
module tb_sstu_datapath;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [7:0] cu_const;
  logic [1:0] insel;
  logic [2:0] in_mux_add;
  logic [3:0] out_mux_add;
  logic [3:0] reg_add;
  logic       we;
  logic [7:0] data_out;
  logic       out_valid;
  logic       z;
  logic       co;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] S_A = 3'd0, S_B = 3'd1, S_C = 3'd2, S_ALU = 3'd3, S_FB = 3'd4;
  localparam logic [1:0] I_AND = 2'd0, I_XOR = 2'd1, I_ADD = 2'd2, I_ROL = 2'd3;

  sstu_datapath dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_in        (a_in),
    .b_in        (b_in),
    .cu_const    (cu_const),
    .insel       (insel),
    .in_mux_add  (in_mux_add),
    .out_mux_add (out_mux_add),
    .reg_add     (reg_add),
    .we          (we),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .z           (z),
    .co          (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One write cycle; afterwards we is dropped and outputs are post-edge.
  task automatic wr(input logic [3:0] addr, input logic [2:0] src, input logic [3:0] fb);
    reg_add     = addr;
    in_mux_add  = src;
    out_mux_add = fb;
    we          = 1'b1;
    cyc();
    we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; a_in = '0; b_in = '0; cu_const = 8'hFF; insel = I_AND;
    in_mux_add = '0; out_mux_add = '0; reg_add = '0; we = 1'b0;
    #12;
    check("rst_data_out", data_out, 8'h00);
    check("rst_out_valid", {7'd0, out_valid}, 8'h00);
    check("rst_z", {7'd0, z}, 8'h01);
    check("rst_co", {7'd0, co}, 8'h00);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Rotate of inA
    a_in = 8'h05; wr(4'd1, S_A, 4'd0);
    insel = I_ROL; #1;
    check("rol_z", {7'd0, z}, 8'h00);
    check("rol_co", {7'd0, co}, 8'h00);
    wr(4'd0, S_ALU, 4'd0);
    check("rol_result", data_out, 8'h0A);
    check("rol_ov", {7'd0, out_valid}, 8'h01);
    cyc();
    check("ov_pulse_end", {7'd0, out_valid}, 8'h00);
    a_in = 8'h00; wr(4'd1, S_A, 4'd0);
    check("rol_zero_z", {7'd0, z}, 8'h01);

    // Decrement idiom
    a_in = 8'h03; wr(4'd1, S_A, 4'd0);
    cu_const = 8'hFF; wr(4'd2, S_C, 4'd0);
    insel = I_ADD; #1;
    check("dec3_co", {7'd0, co}, 8'h01);
    check("dec3_z", {7'd0, z}, 8'h00);
    wr(4'd0, S_ALU, 4'd0);
    check("dec3_result", data_out, 8'h02);
    a_in = 8'h01; wr(4'd1, S_A, 4'd0);
    check("dec1_z", {7'd0, z}, 8'h01);
    check("dec1_co", {7'd0, co}, 8'h01);
    a_in = 8'h00; wr(4'd1, S_A, 4'd0);
    check("dec0_co", {7'd0, co}, 8'h00);
    check("dec0_z", {7'd0, z}, 8'h00);
    wr(4'd0, S_ALU, 4'd0);
    check("dec0_result", data_out, 8'hFF);

    // Constant one, with ALU result written back into inA
    a_in = 8'hFF; wr(4'd1, S_A, 4'd0);
    check("ff_add_co", {7'd0, co}, 8'h01);
    wr(4'd0, S_ALU, 4'd0);
    check("ff_add_result", data_out, 8'hFE);
    reg_add = 4'd1; in_mux_add = S_ALU; we = 1'b1; #1;
    check("wb_old_co", {7'd0, co}, 8'h01);
    cyc();
    we = 1'b0;
    check("wb_new_co", {7'd0, co}, 8'h01);  // FE + FF carries
    insel = I_XOR; #1;
    check("xor_z", {7'd0, z}, 8'h00);
    check("xor_co", {7'd0, co}, 8'h00);
    wr(4'd4, S_ALU, 4'd0);
    wr(4'd0, S_FB, 4'd4);
    check("reg4_one", data_out, 8'h01);

    // Feedback into inA, and same-address read/write
    a_in = 8'h07; wr(4'd6, S_A, 4'd0);
    wr(4'd1, S_FB, 4'd6);
    insel = I_AND;
    wr(4'd0, S_ALU, 4'd0);
    check("fb_inA", data_out, 8'h07);
    a_in = 8'h00; wr(4'd6, S_FB, 4'd6);
    wr(4'd0, S_FB, 4'd6);
    check("fb_same_addr", data_out, 8'h07);

    // Output register from feedback, pulse and hold
    a_in = 8'h51; wr(4'd4, S_A, 4'd0);
    cyc();
    check("idle_ov", {7'd0, out_valid}, 8'h00);
    wr(4'd0, S_FB, 4'd4);
    check("out_51", data_out, 8'h51);
    check("out_51_ov", {7'd0, out_valid}, 8'h01);
    cyc();
    check("out_51_ov_drop", {7'd0, out_valid}, 8'h00);
    a_in = 8'hAA; in_mux_add = S_A; reg_add = 4'd0; cyc(); cyc();
    check("we0_hold", data_out, 8'h51);
    check("we0_ov", {7'd0, out_valid}, 8'h00);

    // Back-to-back writes to address 0
    a_in = 8'h11; wr(4'd0, S_A, 4'd0);
    check("b2b_ov1", {7'd0, out_valid}, 8'h01);
    a_in = 8'h22; wr(4'd0, S_A, 4'd0);
    check("b2b_ov2", {7'd0, out_valid}, 8'h01);
    check("b2b_data", data_out, 8'h22);
    cyc();
    check("b2b_ov_end", {7'd0, out_valid}, 8'h00);

    // Asynchronous reset between edges
    a_in = 8'h33; wr(4'd0, S_A, 4'd0);
    insel = I_ADD;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_data_out", data_out, 8'h00);
    check("arst_ov", {7'd0, out_valid}, 8'h00);
    check("arst_z", {7'd0, z}, 8'h01);
    check("arst_co", {7'd0, co}, 8'h00);
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    check("post_rst_hold", data_out, 8'h00);
    check("post_rst_ov", {7'd0, out_valid}, 8'h00);
    wr(4'd0, S_FB, 4'd4);
    check("post_rst_reg4", data_out, 8'h00);
    wr(4'd0, S_FB, 4'd6);
    check("post_rst_reg6", data_out, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
